// File: rtl/s_mem_arbiter_if.sv
// s_mem_arbiter_if: requester-side bundle of the S memory arbiter.
// Carries each requester's request/address/data/write-enable towards the
// arbiter and the grant, read data and read-valid strobes back.
interface s_mem_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 8,
  parameter int DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wrdata;
  logic [N_REQ-1:0]    req_wren;
  logic [DW-1:0]       rddata;
  logic [N_REQ-1:0]    rdvalid;
  logic                busy;

  // Requesters (RC4 engines) drive requests and consume grant/read return.
  modport master (
    output req, req_addr, req_wrdata, req_wren,
    input  gnt, rddata, rdvalid, busy
  );

  // The arbiter consumes requests and drives grant/read return.
  modport slave (
    input  req, req_addr, req_wrdata, req_wren,
    output gnt, rddata, rdvalid, busy
  );
endinterface

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: shares the single 256x8 S RAM (1-cycle read latency)
// between the RC4 init, ksa and prga engines. One owner at a time holds a
// locked grant for as long as it keeps req high; its addr/data/wren are
// muxed onto the RAM port and its reads come back with an rdvalid strobe.
// Build option: define S_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// the default build uses fixed priority (lowest index wins).
module s_mem_arbiter #(
  parameter int N_REQ = 3,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  s_mem_arbiter_if.slave    bus,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wrdata,
  output logic              mem_wren,
  input  logic [DW-1:0]     mem_rddata
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_rdvalid;

  logic [N_REQ-1:0] w_active;
  logic             w_keep;
  logic             w_any_req;
  logic [PW-1:0]    w_start;
  logic [PW-1:0]    w_win;
  logic [N_REQ-1:0] w_win_oh;

`ifdef S_ARB_ROUND_ROBIN_EN
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptr_nxt;
  assign w_start   = r_ptr;
  assign w_ptr_nxt = (w_win == PW'(N_REQ-1)) ? '0 : PW'(w_win + 1'b1);
`else
  assign w_start   = '0;
`endif

  // First requester found scanning upward from start, wrapping modulo N_REQ.
  function automatic logic [PW-1:0] f_pick(input logic [N_REQ-1:0] r,
                                           input logic [PW-1:0]    start);
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    win = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      idx = PW'((int'(start) + i) % N_REQ);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  // A requester is "active" only while it both holds the grant and keeps req.
  assign w_active  = r_gnt & bus.req;
  assign w_keep    = |w_active;
  assign w_any_req = |bus.req;
  assign w_win     = f_pick(bus.req, w_start);

  // Winner index expanded to a one-hot grant vector.
  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  // Ownership FSM: grant on request from idle, lock while owner holds req,
  // hand over directly (no bubble) or fall back to idle when owner releases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gnt     <= '0;
      r_rdvalid <= '0;
`ifdef S_ARB_ROUND_ROBIN_EN
      r_ptr     <= '0;
`endif
    end else begin
      r_rdvalid <= w_active & ~bus.req_wren;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state <= ST_OWNED;
            r_gnt   <= w_win_oh;
`ifdef S_ARB_ROUND_ROBIN_EN
            r_ptr   <= w_ptr_nxt;
`endif
          end
        end
        ST_OWNED: begin
          if (!w_keep) begin
            if (w_any_req) begin
              r_gnt   <= w_win_oh;
`ifdef S_ARB_ROUND_ROBIN_EN
              r_ptr   <= w_ptr_nxt;
`endif
            end else begin
              r_state <= ST_IDLE;
              r_gnt   <= '0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  // RAM port mux: active owner's slices; otherwise requester 0 slices with
  // wren forced low; all-zero while reset is asserted.
  always_comb begin
    mem_addr   = bus.req_addr[AW-1:0];
    mem_wrdata = bus.req_wrdata[DW-1:0];
    mem_wren   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_active[k]) begin
        mem_addr   = bus.req_addr[k*AW +: AW];
        mem_wrdata = bus.req_wrdata[k*DW +: DW];
        mem_wren   = bus.req_wren[k];
      end
    end
    if (!rst_n) begin
      mem_addr   = '0;
      mem_wrdata = '0;
      mem_wren   = 1'b0;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.rdvalid = r_rdvalid;
  assign bus.busy    = |r_gnt;
  assign bus.rddata  = mem_rddata;

endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb_s_mem_arbiter: self-checking bench for s_mem_arbiter with a behavioural
// ownership/memory model. Honours S_ARB_ROUND_ROBIN_EN when defined.
module tb_s_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  s_mem_arbiter_if #(.N_REQ(3), .AW(8), .DW(8)) bus ();

  logic [7:0] mem_addr, mem_wrdata, mem_rddata;
  logic       mem_wren;

  s_mem_arbiter #(.N_REQ(3), .AW(8), .DW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .mem_addr   (mem_addr),
    .mem_wrdata (mem_wrdata),
    .mem_wren   (mem_wren),
    .mem_rddata (mem_rddata)
  );

  // S RAM: synchronous write, registered read (old data on collision).
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wrdata;
    mem_rddata <= ram[mem_addr];
  end

  // Requester stimulus.
  logic [2:0] req_v, wren_v;
  logic [7:0] a_v [3];
  logic [7:0] d_v [3];
  assign bus.req        = req_v;
  assign bus.req_wren   = wren_v;
  assign bus.req_addr   = {a_v[2], a_v[1], a_v[0]};
  assign bus.req_wrdata = {d_v[2], d_v[1], d_v[0]};

  // Reference model: who owns the memory, what it has written, what it read.
  logic       m_busy, n_busy, m_act;
  logic [1:0] m_own, n_own, m_ptr, n_ptr, start;
  logic [2:0] m_rdv, exp_gnt;
  logic [7:0] m_rdata;
  logic [7:0] shadow [256];
  logic       exp_wren;

`ifdef S_ARB_ROUND_ROBIN_EN
  assign start = m_ptr;
`else
  assign start = 2'd0;
`endif

  always_comb begin
    m_act  = m_busy && req_v[m_own];
    n_busy = m_busy;
    n_own  = m_own;
    n_ptr  = m_ptr;
    if (!m_act) begin
      n_busy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        logic [1:0] cand;
        cand = 2'((int'(start) + i) % 3);
        if (!n_busy && req_v[cand]) begin
          n_busy = 1'b1;
          n_own  = cand;
        end
      end
      if (n_busy) n_ptr = (n_own == 2'd2) ? 2'd0 : n_own + 2'd1;
    end
    exp_gnt  = m_busy ? (3'b001 << m_own) : 3'b000;
    exp_wren = m_act && wren_v[m_own];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_own  <= 2'd0;
      m_ptr  <= 2'd0;
      m_rdv  <= 3'b000;
    end else begin
      m_busy <= n_busy;
      m_own  <= n_own;
      m_ptr  <= n_ptr;
      m_rdv  <= (m_act && !wren_v[m_own]) ? (3'b001 << m_own) : 3'b000;
      if (m_act && !wren_v[m_own]) m_rdata <= shadow[a_v[m_own]];
      if (m_act && wren_v[m_own])  shadow[a_v[m_own]] <= d_v[m_own];
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    req_v  = 3'b111;
    wren_v = 3'b111;
    a_v[0] = 8'h33; a_v[1] = 8'h22; a_v[2] = 8'h11;
    d_v[0] = 8'hC3; d_v[1] = 8'hC2; d_v[2] = 8'hC1;
    tick(); tick();
    n_cmp++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL reset_gnt got %b want 000", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren got %b want 0", mem_wren); end
    n_cmp++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr got %h want 00", mem_addr); end
    n_cmp++; if (mem_wrdata !== 8'h00) begin n_fail++; $display("FAIL reset_wrdata got %h want 00", mem_wrdata); end
    n_cmp++; if (bus.rdvalid !== 3'b000) begin n_fail++; $display("FAIL reset_rdvalid got %b want 000", bus.rdvalid); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL release_gnt got %b want 001", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL release_busy got %b want 1", bus.busy); end
    req_v  = 3'b000;
    wren_v = 3'b000;
    tick();
    n_cmp++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL release_idle got %b want 000", bus.gnt); end
  endtask

  task automatic test_init_sweep();
    int w;
    req_v  = 3'b001;
    wren_v = 3'b001;
    a_v[0] = 8'h00; d_v[0] = 8'h00;
    w = 0;
    while (bus.gnt[0] !== 1'b1 && w < 8) begin tick(); w++; end
    n_cmp++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL sweep_gnt0 got %b want 001", bus.gnt); end
    for (int i = 0; i < 256; i++) begin
      a_v[0] = 8'(i);
      d_v[0] = 8'(i);
      if (i == 100) req_v[1] = 1'b1;
      tick();
      n_cmp++;
      if (bus.gnt !== 3'b001 || bus.gnt !== exp_gnt) begin
        n_fail++; $display("FAIL sweep_lock i=%0d got %b want 001 (model %b)", i, bus.gnt, exp_gnt);
      end
    end
    req_v[0]  = 1'b0;
    wren_v[0] = 1'b0;
    tick();
    n_cmp++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL sweep_handover got %b want 010", bus.gnt); end
    for (int i = 0; i < 256; i++) begin
      n_cmp++;
      if (ram[i] !== 8'(i)) begin n_fail++; $display("FAIL sweep_mem addr=%0d got %h want %h", i, ram[i], 8'(i)); end
    end
    req_v = 3'b000;
    tick();
  endtask

  task automatic test_read_latency();
    int w;
    req_v  = 3'b010;
    wren_v = 3'b000;
    a_v[1] = 8'h3C;
    w = 0;
    while (bus.gnt[1] !== 1'b1 && w < 8) begin tick(); w++; end
    n_cmp++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL rd_gnt got %b want 010", bus.gnt); end
    n_cmp++; if (bus.rdvalid !== 3'b000) begin n_fail++; $display("FAIL rd_early got %b want 000", bus.rdvalid); end
    tick();
    n_cmp++; if (bus.rdvalid !== 3'b010) begin n_fail++; $display("FAIL rd_valid got %b want 010", bus.rdvalid); end
    n_cmp++; if (bus.rddata !== 8'h3C) begin n_fail++; $display("FAIL rd_data got %h want 3c", bus.rddata); end
  endtask

  task automatic test_back_to_back();
    for (int j = 0; j < 3; j++) begin
      a_v[1] = 8'(j);
      tick();
      n_cmp++; if (bus.rdvalid !== 3'b010) begin n_fail++; $display("FAIL b2b_valid j=%0d got %b want 010", j, bus.rdvalid); end
      n_cmp++; if (bus.rddata !== 8'(j)) begin n_fail++; $display("FAIL b2b_data j=%0d got %h want %h", j, bus.rddata, 8'(j)); end
    end
    req_v = 3'b000;
    tick();
    n_cmp++; if (bus.rdvalid !== 3'b000) begin n_fail++; $display("FAIL b2b_end_valid got %b want 000", bus.rdvalid); end
    n_cmp++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL b2b_end_gnt got %b want 000", bus.gnt); end
  endtask

  task automatic test_ungranted_write();
    int w;
    req_v  = 3'b001;
    wren_v = 3'b000;
    a_v[0] = 8'h00;
    w = 0;
    while (bus.gnt[0] !== 1'b1 && w < 8) begin tick(); w++; end
    n_cmp++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL ugw_gnt0 got %b want 001", bus.gnt); end
    req_v[2] = 1'b1; wren_v[2] = 1'b1; a_v[2] = 8'h55; d_v[2] = 8'hAA;
    for (int j = 0; j < 5; j++) begin
      tick();
      n_cmp++; if (bus.gnt !== 3'b001) begin n_fail++; $display("FAIL ugw_lock j=%0d got %b want 001", j, bus.gnt); end
      n_cmp++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL ugw_wren j=%0d got %b want 0", j, mem_wren); end
    end
    n_cmp++; if (ram[8'h55] !== 8'h55) begin n_fail++; $display("FAIL ugw_mem got %h want 55", ram[8'h55]); end
    req_v[0]  = 1'b0;
    wren_v[2] = 1'b0;
    tick();
    n_cmp++; if (bus.gnt !== 3'b100) begin n_fail++; $display("FAIL ugw_handover got %b want 100", bus.gnt); end
    n_cmp++; if (ram[8'h55] !== 8'h55) begin n_fail++; $display("FAIL ugw_mem_after got %h want 55", ram[8'h55]); end
    req_v = 3'b000;
    tick();
  endtask

  task automatic test_contention();
    int order [6];
    int exp_order [6];
    int n_got;
    int cnt [3];
    logic [2:0] prev;
`ifdef S_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 2, 0, 1, 2};
`else
    exp_order = '{0, 1, 0, 1, 0, 1};
`endif
    cnt = '{0, 0, 0};
    order = '{-1, -1, -1, -1, -1, -1};
    n_got = 0;
    prev  = 3'b000;
    req_v  = 3'b000;
    wren_v = 3'b000;
    tick();
    req_v = 3'b111;
    for (int c = 0; c < 80 && n_got < 6; c++) begin
      tick();
      n_cmp++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL cont_model c=%0d got %b want %b", c, bus.gnt, exp_gnt); end
      if (bus.gnt !== prev && bus.gnt !== 3'b000) begin
        for (int k = 0; k < 3; k++) if (bus.gnt[k]) order[n_got] = k;
        n_got++;
      end
      prev = bus.gnt;
      for (int k = 0; k < 3; k++) begin
        if (req_v[k] && bus.gnt[k]) begin
          cnt[k]++;
          if (cnt[k] == 4) begin req_v[k] = 1'b0; cnt[k] = 0; end
        end else if (!req_v[k]) begin
          req_v[k] = 1'b1;
        end
      end
    end
    n_cmp++; if (n_got !== 6) begin n_fail++; $display("FAIL cont_timeout got %0d grants want 6", n_got); end
    for (int j = 0; j < 6; j++) begin
      n_cmp++;
      if (order[j] !== exp_order[j]) begin n_fail++; $display("FAIL cont_order j=%0d got %0d want %0d", j, order[j], exp_order[j]); end
    end
    req_v = 3'b000;
    tick(); tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) req_v[k] = ~req_v[k];
        a_v[k] = 8'($urandom);
        d_v[k] = 8'($urandom);
      end
      wren_v = 3'($urandom);
      tick();
      n_cmp++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL rnd_gnt c=%0d got %b want %b", c, bus.gnt, exp_gnt); end
      n_cmp++; if (bus.rdvalid !== m_rdv) begin n_fail++; $display("FAIL rnd_rdvalid c=%0d got %b want %b", c, bus.rdvalid, m_rdv); end
      n_cmp++; if (bus.busy !== (exp_gnt != 3'b000)) begin n_fail++; $display("FAIL rnd_busy c=%0d got %b", c, bus.busy); end
      n_cmp++; if (mem_wren !== exp_wren) begin n_fail++; $display("FAIL rnd_wren c=%0d got %b want %b", c, mem_wren, exp_wren); end
      if (m_rdv != 3'b000) begin
        n_cmp++; if (bus.rddata !== m_rdata) begin n_fail++; $display("FAIL rnd_rddata c=%0d got %h want %h", c, bus.rddata, m_rdata); end
      end
    end
    req_v  = 3'b000;
    wren_v = 3'b000;
    tick(); tick();
  endtask

  task automatic test_async_reset();
    int w;
    req_v  = 3'b010;
    wren_v = 3'b000;
    a_v[1] = 8'h03;
    w = 0;
    while (bus.gnt[1] !== 1'b1 && w < 8) begin tick(); w++; end
    n_cmp++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL ar_gnt got %b want 010", bus.gnt); end
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.gnt !== 3'b000) begin n_fail++; $display("FAIL ar_gnt_drop got %b want 000", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.rdvalid !== 3'b000) begin n_fail++; $display("FAIL ar_rdvalid got %b want 000", bus.rdvalid); end
    n_cmp++; if (mem_wren !== 1'b0) begin n_fail++; $display("FAIL ar_wren got %b want 0", mem_wren); end
    #1 rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.rdvalid !== 3'b000) begin n_fail++; $display("FAIL ar_no_rdvalid got %b want 000", bus.rdvalid); end
    n_cmp++; if (bus.gnt !== 3'b010) begin n_fail++; $display("FAIL ar_regrant got %b want 010", bus.gnt); end
    tick();
    n_cmp++; if (bus.rdvalid !== 3'b010) begin n_fail++; $display("FAIL ar_read_resume got %b want 010", bus.rdvalid); end
    req_v = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_read_latency();
    test_back_to_back();
    test_ungranted_write();
    test_contention();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
